// File: rtl/axi_ram_responder_if.sv
// AXI4 slave-side bus bundle for axi_ram_responder: AW/W/B write channels and AR/R read channels.
interface axi_ram_responder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_responder.sv
// AXI4 memory slave: independent read and write FSMs (one burst each) sharing a byte-writable RAM.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write command
// W_DATA | accepting awlen+1 write beats
// W_RESP | presenting the B response
// R_IDLE | arready high, waiting for a read command
// R_DATA | presenting registered read beats
module axi_ram_responder #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 6,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input logic                clk,
  input logic                rstn,
  axi_ram_responder_if.slave s_axi
);
  localparam int OFS_W = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFS_W;
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state, w_state_nxt;
  r_state_t              r_state, r_state_nxt;
  logic                  out_en;
  logic [ID_WIDTH-1:0]   w_id, r_id;
  logic [IDX_W-1:0]      w_idx, r_idx, rd_idx;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic                  w_fixed, r_fixed, w_err;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, rd_load;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic                  unused_bits;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return idx[IDX_W-1:MEM_WORDS_LOG2] == '0;
  endfunction

  // Holds both readies low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) out_en <= 1'b0;
    else       out_en <= 1'b1;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end

  always_comb begin
    w_state_nxt   = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi.awready = out_en;
        if (s_axi.awvalid && out_en) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_cnt == w_len) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.arready = out_en;
        if (s_axi.arvalid && out_en) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready && rlast_q) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid  & s_axi.wready;
  assign b_hs  = s_axi.bvalid  & s_axi.bready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;
  assign r_hs  = s_axi.rvalid  & s_axi.rready;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id    <= s_axi.awid;
        w_idx   <= s_axi.awaddr[ADDR_WIDTH-1:OFS_W];
        w_len   <= s_axi.awlen;
        w_fixed <= s_axi.awburst == 2'b00;
        w_cnt   <= '0;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (!w_fixed) w_idx <= w_idx + IDX_ONE;
        if (!in_range(w_idx)) w_err <= 1'b1;
      end
      if (b_hs) w_err <= 1'b0;
    end

  always_ff @(posedge clk)
    if (w_hs && in_range(w_idx))
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi.wstrb[b]) mem[w_idx[MEM_WORDS_LOG2-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];

  // The RAM is read on the AR handshake and on every non-final beat handshake, so the
  // next beat is registered one cycle later; a write to the same word that cycle is not seen.
  assign rd_idx  = ar_hs ? s_axi.araddr[ADDR_WIDTH-1:OFS_W] :
                   (r_fixed ? r_idx : r_idx + IDX_ONE);
  assign rd_load = ar_hs | (r_hs & ~rlast_q);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi.arid;
        r_len   <= s_axi.arlen;
        r_fixed <= s_axi.arburst == 2'b00;
        r_cnt   <= '0;
        rlast_q <= s_axi.arlen == 8'd0;
      end else if (r_hs && !rlast_q) begin
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= (r_cnt + 8'd1) == r_len;
      end
      if (rd_load) begin
        r_idx <= rd_idx;
        if (in_range(rd_idx)) begin
          rdata_q <= mem[rd_idx[MEM_WORDS_LOG2-1:0]];
          rresp_q <= 2'b00;
        end else begin
          rdata_q <= '0;
          rresp_q <= 2'b10;
        end
      end
    end

  assign s_axi.bid   = w_id;
  assign s_axi.bresp = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
  assign s_axi.rid   = r_id;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rlast = rlast_q;

  assign unused_bits = ^{s_axi.wlast, s_axi.awsize, s_axi.arsize,
                         s_axi.awaddr[OFS_W-1:0], s_axi.araddr[OFS_W-1:0]};
endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder, checked against a byte-level RAM model kept here.
module tb_axi_ram_responder;
  localparam int DW = 128, AW = 32, IW = 6, SW = 16, MLOG = 12, DEPTH = 4096;

  typedef logic [DW-1:0] data_q_t[$];
  typedef logic [SW-1:0] strb_q_t[$];

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_ram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) axi ();

  axi_ram_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW), .MEM_WORDS_LOG2(MLOG)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s_axi(axi)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model_mem   [DEPTH];
  logic [SW-1:0] model_known [DEPTH];
  logic [DW-1:0] last_rdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint beat_word(input logic [AW-1:0] addr, input logic [1:0] burst, input int k);
    longint base;
    base = longint'(addr) / SW;
    return (burst == 2'b00) ? base : base + k;
  endfunction

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    for (int b = 0; b < SW; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input data_q_t data, input strb_q_t strb,
                           input int bdelay);
    bit err = 0;
    int t;
    for (int k = 0; k <= int'(len); k++) begin
      longint w = beat_word(addr, burst, k);
      if (w < DEPTH) begin
        logic [DW-1:0] m = byte_mask(strb[k]);
        model_mem[w]   = (model_mem[w] & ~m) | (data[k] & m);
        model_known[w] = model_known[w] | strb[k];
      end else err = 1;
    end
    @(negedge clk);
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd4;
    axi.awburst = burst; axi.awvalid = 1'b1;
    t = 0;
    while (!axi.awready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("awready_timeout", 0, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if ($urandom_range(0, 3) == 0) begin
        axi.wvalid = 1'b0;
        @(negedge clk);
      end
      axi.wdata = data[k]; axi.wstrb = strb[k]; axi.wlast = (k == int'(len)); axi.wvalid = 1'b1;
      t = 0;
      while (!axi.wready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("wready_timeout", 0, 1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    check("bvalid_after_last_w", axi.bvalid, 1);
    for (int d = 0; d < bdelay; d++) begin
      check("bvalid_held", axi.bvalid, 1);
      check("awready_during_b", axi.awready, 0);
      @(negedge clk);
    end
    axi.bready = 1'b1;
    check("bid", axi.bid, id);
    check("bresp", axi.bresp, err ? 2'b10 : 2'b00);
    @(negedge clk);
    axi.bready = 1'b0;
    check("bvalid_after_b", axi.bvalid, 0);
    check("awready_after_b", axi.awready, 1);
  endtask

  // rmode: 0 rready held high, 1 toggled every cycle, 2 random
  task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int rmode);
    int t, k, cyc;
    bit stalled = 0, tog = 0, rr;
    logic [DW-1:0] s_data;
    logic [1:0] s_resp;
    logic s_last;
    @(negedge clk);
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd4;
    axi.arburst = burst; axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("arready_timeout", 0, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("rvalid_latency", axi.rvalid, 1);
    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 500) begin
      check("rvalid_in_burst", axi.rvalid, 1);
      if (stalled) begin
        check("rdata_stable", axi.rdata, s_data);
        check("rresp_stable", axi.rresp, s_resp);
        check("rlast_stable", axi.rlast, s_last);
      end
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      axi.rready = rr;
      if (axi.rvalid && rr) begin
        longint w = beat_word(addr, burst, k);
        check("rid", axi.rid, id);
        check("rlast", axi.rlast, k == int'(len));
        if (w < DEPTH) begin
          logic [DW-1:0] m = byte_mask(model_known[w]);
          check("rdata", axi.rdata & m, model_mem[w] & m);
          check("rresp_ok", axi.rresp, 2'b00);
        end else begin
          check("rdata_oor", axi.rdata, 0);
          check("rresp_oor", axi.rresp, 2'b10);
        end
        last_rdata = axi.rdata;
        k++;
        stalled = 0;
      end else begin
        stalled = axi.rvalid;
        s_data = axi.rdata; s_resp = axi.rresp; s_last = axi.rlast;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) check("read_timeout", 0, 1);
    axi.rready = 1'b0;
    check("rvalid_after_last", axi.rvalid, 0);
    check("arready_after_read", axi.arready, 1);
  endtask

  initial begin
    data_q_t dq;
    strb_q_t sq;
    int t;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_known[i] = '0; end
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 0;
    axi.rready = 0;

    #12;
    check("rst_awready", axi.awready, 0);
    check("rst_arready", axi.arready, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_wready", axi.wready, 0);
    check("rst_bid_bresp", {axi.bid, axi.bresp}, 0);
    check("rst_rid_rresp_rlast", {axi.rid, axi.rresp, axi.rlast}, 0);
    check("rst_rdata", axi.rdata, 0);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);

    // INCR write then read back
    dq = '{128'hA0, 128'hA1, 128'hA2, 128'hA3}; sq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    axi_write(6'd5, 32'h100, 8'd3, 2'b01, dq, sq, 0);
    axi_read(6'd9, 32'h100, 8'd3, 2'b01, 0);
    check("incr_last_beat", last_rdata, 128'hA3);

    // partial strobe
    dq = '{{DW{1'b1}}}; sq = '{16'hFFFF};
    axi_write(6'd1, 32'h0, 8'd0, 2'b01, dq, sq, 1);
    dq = '{128'h0}; sq = '{16'h000F};
    axi_write(6'd2, 32'h0, 8'd0, 2'b01, dq, sq, 0);
    axi_read(6'd3, 32'h0, 8'd0, 2'b01, 0);
    check("partial_strobe", last_rdata, {{96{1'b1}}, 32'h0});

    // R backpressure
    dq.delete(); sq.delete();
    for (int k = 0; k < 8; k++) begin dq.push_back({$urandom, $urandom, $urandom, $urandom}); sq.push_back(16'hFFFF); end
    axi_write(6'd7, 32'h200, 8'd7, 2'b01, dq, sq, 0);
    axi_read(6'd8, 32'h200, 8'd7, 2'b01, 1);
    check("backpressure_last", last_rdata, dq[7]);

    // out of range at the top word
    dq = '{128'h1234_5678, 128'h9ABC}; sq = '{16'hFFFF, 16'hFFFF};
    axi_write(6'd10, 32'((DEPTH - 1) * SW), 8'd1, 2'b01, dq, sq, 0);
    axi_read(6'd11, 32'((DEPTH - 1) * SW), 8'd1, 2'b01, 0);

    // FIXED burst with B held off
    dq = '{128'd1, 128'd2, 128'd3}; sq = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    axi_write(6'd12, 32'h300, 8'd2, 2'b00, dq, sq, 5);
    axi_read(6'd13, 32'h300, 8'd0, 2'b01, 0);
    check("fixed_final", last_rdata, 128'd3);
    axi_read(6'd14, 32'h300, 8'd2, 2'b00, 2);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      logic [AW-1:0] a;
      logic [7:0] len;
      logic [1:0] bt;
      int word;
      word = $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(DEPTH - 8, DEPTH - 1);
      a = AW'(word * SW) | AW'($urandom_range(0, SW - 1));
      len = 8'($urandom_range(0, 7));
      bt = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1)) begin
        dq.delete(); sq.delete();
        for (int k = 0; k <= int'(len); k++) begin
          dq.push_back({$urandom, $urandom, $urandom, $urandom});
          sq.push_back(16'($urandom));
        end
        axi_write(6'($urandom), a, len, bt, dq, sq, $urandom_range(0, 3));
      end else begin
        axi_read(6'($urandom), a, len, bt, $urandom_range(0, 2));
      end
    end

    // reset during beat 3 of an 8-beat read
    @(negedge clk);
    axi.arid = 6'd20; axi.araddr = 32'h200; axi.arlen = 8'd7; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("arready_timeout", 0, 1);
    @(negedge clk);
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    axi.rready = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_rvalid", axi.rvalid, 0);
    check("midrst_arready", axi.arready, 0);
    check("midrst_rdata", axi.rdata, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_arready", axi.arready, 1);
    check("postrst_awready", axi.awready, 1);
    axi_read(6'd21, 32'h200, 8'd7, 2'b01, 0);
    axi_read(6'd22, 32'h100, 8'd3, 2'b01, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
